vga_window_reader: RTL

- Parametrised VGA timing generator and framebuffer window reader.
- Produces sync and active-video timing and reads a WIN_W x WIN_H image from a synchronous-read frame memory.
- Places the image at a runtime-selectable position, with a background colour elsewhere in the active area.
- Delays sync, data-enable and colour by the memory read latency so all VGA outputs stay aligned. Sits between the frame BRAM and the VGA DAC pins.

---
 rtl/vga_window_reader_if.sv | 30 +++
 rtl/vga_window_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_window_reader_if.sv
// ---------------------------------------------------------------------------
// vga_window_reader_if
//   Read port between the VGA window reader and its synchronous frame memory.
//
//   frame_addr : word address of the pixel being fetched
//   rd_en      : read strobe, high for every in-window pixel
//   vga_in     : read data, valid MEM_LAT cycles after frame_addr
//
//   master : the reader (drives address/strobe, receives data)
//   slave  : the memory (receives address/strobe, drives data)
// ---------------------------------------------------------------------------
interface vga_window_reader_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] frame_addr;
    logic              rd_en;
    logic [15:0]       vga_in;

    modport master (
        output frame_addr,
        output rd_en,
        input  vga_in
    );

    modport slave (
        input  frame_addr,
        input  rd_en,
        output vga_in
    );
endinterface

// File: rtl/vga_window_reader.sv
// ---------------------------------------------------------------------------
// vga_window_reader
//   VGA timing generator plus framebuffer window reader. A WIN_W x WIN_H
//   image is fetched from a synchronous-read memory and placed at
//   (win_x, win_y) inside the active area; other active pixels show
//   bg_color. Syncs, data-enable and colour are all delayed by the memory
//   read latency so they arrive at the pins together (MEM_LAT+2 cycles
//   after the raw counter value).
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   en                  timing enable (low: counters held at 0, output blank)
//   win_x, win_y        window position, latched at the last pixel of a frame
//   bg_color            RGB565 colour for active pixels outside the window
//   mem                 frame memory read port (frame_addr, rd_en, vga_in)
//   vga_red/green/blue  RGB565 colour to the DAC
//   vga_hsync/vsync     syncs, active level set by HSYNC_POL / VSYNC_POL
//   vga_de              active-video flag
//   frame_start         one-cycle pulse with output pixel (0,0)
//   h_cnt, v_cnt        raw stage-0 counters
// ---------------------------------------------------------------------------
module vga_window_reader #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int WIN_W     = 320,
    parameter int WIN_H     = 240,
    parameter int ADDR_W    = 17,
    parameter int MEM_LAT   = 1,
    parameter int GRAY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [9:0]           win_x,
    input  logic [9:0]           win_y,
    input  logic [15:0]          bg_color,
    vga_window_reader_if.master  mem,
    output logic [4:0]           vga_red,
    output logic [5:0]           vga_green,
    output logic [4:0]           vga_blue,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_de,
    output logic                 frame_start,
    output logic [9:0]           h_cnt,
    output logic [9:0]           v_cnt
);

    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_STOP  = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_STOP  = VS_START + V_SYNC;
    // flag pipeline depth: flags meet vga_in, which trails frame_addr by MEM_LAT
    localparam int DLY      = MEM_LAT + 1;

    localparam logic [9:0] H_LAST = 10'(HT - 1);
    localparam logic [9:0] V_LAST = 10'(VT - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic       HS_ON  = 1'(HSYNC_POL);
    localparam logic       VS_ON  = 1'(VSYNC_POL);

    typedef struct packed {
        logic active;
        logic in_win;
        logic hs;
        logic vs;
        logic fs;
    } flags_t;

    // ------------------------------------------------------------------
    // Stage 0: counters and window registers
    // ------------------------------------------------------------------
    // en is registered so a rising en restarts cleanly at (0,0) on the
    // following cycle with counters that were already held at zero.
    logic       en_q;
    logic [9:0] wx;
    logic [9:0] wy;
    logic       eol;
    logic       eof;

    assign eol = (h_cnt == H_LAST);
    assign eof = eol && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            en_q <= en;
            if (!en_q) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (eol) begin
                h_cnt <= '0;
                v_cnt <= eof ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // window position only changes between frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wx <= '0;
            wy <= '0;
        end else if (en_q && eof) begin
            wx <= win_x;
            wy <= win_y;
        end
    end

    // 11-bit window bounds so wx+WIN_W cannot wrap
    logic [10:0] wx_end;
    logic [10:0] wy_end;
    logic        col_in;
    logic        row_in;
    flags_t      f0;

    assign wx_end = {1'b0, wx} + 11'(WIN_W);
    assign wy_end = {1'b0, wy} + 11'(WIN_H);
    assign col_in = (h_cnt >= wx) && ({1'b0, h_cnt} < wx_end);
    assign row_in = (v_cnt >= wy) && ({1'b0, v_cnt} < wy_end);

    always_comb begin
        f0        = '0;
        f0.active = en_q && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        f0.in_win = f0.active && col_in && row_in;
        f0.hs     = en_q && (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_STOP));
        f0.vs     = en_q && (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_STOP));
        f0.fs     = en_q && (h_cnt == '0) && (v_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Stage 1: address generation
    // ------------------------------------------------------------------
    // rd_q is the previous pixel's in_win, so rd_q low marks the first
    // window pixel of a row. row_base advances for every window line even
    // when it is clipped, keeping the WIN_W stride.
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] row_base;
    logic              rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            rd_q     <= 1'b0;
            row_base <= '0;
        end else begin
            rd_q <= f0.in_win;
            if (f0.in_win) begin
                addr_q <= rd_q ? addr_q + 1'b1 : row_base;
            end
            if (!en_q || eof) begin
                row_base <= '0;
            end else if (eol && row_in) begin
                row_base <= row_base + ADDR_W'(WIN_W);
            end
        end
    end

    assign mem.frame_addr = addr_q;
    assign mem.rd_en      = rd_q;

    // ------------------------------------------------------------------
    // Flag delay line and output register
    // ------------------------------------------------------------------
    flags_t pipe [DLY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DLY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= f0;
            for (int unsigned i = 1; i < DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    flags_t      last;
    logic [15:0] px;
    logic [15:0] colour;

    always_comb begin
        last = pipe[DLY-1];
        if (GRAY_MODE != 0) begin
            px = {mem.vga_in[7:3], mem.vga_in[7:2], mem.vga_in[7:3]};
        end else begin
            px = mem.vga_in;
        end
        if (!last.active) begin
            colour = '0;
        end else if (last.in_win) begin
            colour = px;
        end else begin
            colour = bg_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            vga_hsync   <= ~HS_ON;
            vga_vsync   <= ~VS_ON;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_red     <= colour[15:11];
            vga_green   <= colour[10:5];
            vga_blue    <= colour[4:0];
            vga_hsync   <= last.hs ? HS_ON : ~HS_ON;
            vga_vsync   <= last.vs ? VS_ON : ~VS_ON;
            vga_de      <= last.active;
            frame_start <= last.fs;
        end
    end

endmodule
